// File: rtl/video_timing_gen.sv
// video_timing_gen: raster timing master and test-pattern source for the sys video path.
// Produces a one-cycle pixel enable, positive syncs and blanking, RGB and the raster position
// of the pixel currently on the outputs. All outputs are registered in the CLK_VIDEO domain.
//
// Ports:
//   CLK_VIDEO           video clock
//   reset               synchronous, active-high reset
//   pat_sel[2:0]        [2]=1 pattern, [1:0] pattern number; [2]=0 passthrough (latched at frame start)
//   ext_R/ext_G/ext_B   external pixel for passthrough, sampled one pixel ahead of hcnt
//   ce_pix              pixel clock enable, one cycle in every CE_DIV
//   HSync, VSync        positive sync pulses
//   HBlank, VBlank      positive blanking
//   R, G, B             pixel colour, forced to zero in blanking
//   hcnt, vcnt          position of the pixel currently on the outputs
//   frame               frame counter, increments on every transition to (0,0)
//
// Optional feature: define VIDEO_TIMING_GEN_PATTERN_EN to compile in the pattern generator
// (colour bars, grid, gradient, checkerboard). Without it the block is passthrough only.
module video_timing_gen #(
  parameter int unsigned HACTIVE    = 320,
  parameter int unsigned HFP        = 16,
  parameter int unsigned HSW        = 32,
  parameter int unsigned HBP        = 32,
  parameter int unsigned VACTIVE    = 240,
  parameter int unsigned VFP        = 3,
  parameter int unsigned VSW        = 4,
  parameter int unsigned VBP        = 15,
  parameter int unsigned CE_DIV     = 4,
  parameter int unsigned HALF_DEPTH = 0
) (
  input  logic                                    CLK_VIDEO,
  input  logic                                    reset,
  input  logic [2:0]                              pat_sel,
  input  logic [((HALF_DEPTH != 0) ? 4 : 8)-1:0]  ext_R,
  input  logic [((HALF_DEPTH != 0) ? 4 : 8)-1:0]  ext_G,
  input  logic [((HALF_DEPTH != 0) ? 4 : 8)-1:0]  ext_B,
  output logic                                    ce_pix,
  output logic                                    HSync,
  output logic                                    VSync,
  output logic                                    HBlank,
  output logic                                    VBlank,
  output logic [((HALF_DEPTH != 0) ? 4 : 8)-1:0]  R,
  output logic [((HALF_DEPTH != 0) ? 4 : 8)-1:0]  G,
  output logic [((HALF_DEPTH != 0) ? 4 : 8)-1:0]  B,
  output logic [9:0]                              hcnt,
  output logic [9:0]                              vcnt,
  output logic [7:0]                              frame
);

  localparam int unsigned DW   = (HALF_DEPTH != 0) ? 4 : 8;
  localparam int unsigned CW   = 10;
  localparam int unsigned DIVW = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;

  localparam logic [DIVW-1:0] DIV_LAST = DIVW'(CE_DIV - 1);
  localparam logic [CW-1:0]   H_LAST   = CW'(HACTIVE + HFP + HSW + HBP - 1);
  localparam logic [CW-1:0]   V_LAST   = CW'(VACTIVE + VFP + VSW + VBP - 1);
  localparam logic [CW-1:0]   H_ACT    = CW'(HACTIVE);
  localparam logic [CW-1:0]   H_SS     = CW'(HACTIVE + HFP);
  localparam logic [CW-1:0]   H_SE     = CW'(HACTIVE + HFP + HSW);
  localparam logic [CW-1:0]   V_ACT    = CW'(VACTIVE);
  localparam logic [CW-1:0]   V_SS     = CW'(VACTIVE + VFP);
  localparam logic [CW-1:0]   V_SE     = CW'(VACTIVE + VFP + VSW);

  logic [DIVW-1:0] div;
  logic            stb;
  logic [CW-1:0]   h_n, v_n;
  logic            frame_start;
  logic [7:0]      frame_n;
  logic            hblank_n, vblank_n, hsync_n, vsync_n;
  logic [DW-1:0]   r_n, g_n, b_n;

`ifdef VIDEO_TIMING_GEN_PATTERN_EN
  localparam logic [CW-1:0] BAR_LAST   = CW'(HACTIVE / 8 - 1);
  localparam logic [CW-1:0] H_ACT_LAST = CW'(HACTIVE - 1);
  localparam logic [CW-1:0] V_ACT_LAST = CW'(VACTIVE - 1);

  logic [2:0]    pat_q, pat_n;
  logic [CW-1:0] bar_px, bar_px_n;
  logic [2:0]    bar_idx, bar_idx_n;
  logic          grid, check;
`else
  logic unused_pat_sel;
  assign unused_pat_sel = ^pat_sel;
`endif

  // Next raster position, timing decode and colour for the pixel emitted on the next stb.
  always_comb begin
    stb      = (div == DIV_LAST);
    h_n      = hcnt + CW'(1);
    v_n      = vcnt;
    if (hcnt == H_LAST) begin
      h_n = '0;
      v_n = (vcnt == V_LAST) ? '0 : vcnt + CW'(1);
    end
    frame_start = (h_n == '0) && (v_n == '0);
    frame_n     = frame_start ? frame + 8'd1 : frame;
    hblank_n    = (h_n >= H_ACT);
    vblank_n    = (v_n >= V_ACT);
    hsync_n     = (h_n >= H_SS) && (h_n < H_SE);
    vsync_n     = (v_n >= V_SS) && (v_n < V_SE);

    r_n = ext_R;
    g_n = ext_G;
    b_n = ext_B;

`ifdef VIDEO_TIMING_GEN_PATTERN_EN
    // Pattern selection takes effect on the first pixel of a frame.
    pat_n = frame_start ? pat_sel : pat_q;

    // Bar index tracks a pixel sub-counter so no divide by HACTIVE/8 is needed.
    bar_px_n  = bar_px + CW'(1);
    bar_idx_n = bar_idx;
    if (h_n == '0) begin
      bar_px_n  = '0;
      bar_idx_n = '0;
    end else if (bar_px == BAR_LAST) begin
      bar_px_n  = '0;
      bar_idx_n = bar_idx + 3'd1;
    end

    grid  = (h_n[3:0] == 4'd0) || (v_n[3:0] == 4'd0) ||
            (h_n == H_ACT_LAST) || (v_n == V_ACT_LAST);
    check = h_n[4] ^ v_n[4];

    if (pat_n[2]) begin
      case (pat_n[1:0])
        2'd0: begin
          r_n = {DW{~bar_idx_n[1]}};
          g_n = {DW{~bar_idx_n[2]}};
          b_n = {DW{~bar_idx_n[0]}};
        end
        2'd1: begin
          r_n = {DW{grid}};
          g_n = {DW{grid}};
          b_n = {DW{grid}};
        end
        2'd2: begin
          r_n = h_n[DW-1:0];
          g_n = v_n[DW-1:0];
          b_n = frame_n[DW-1:0];
        end
        default: begin
          r_n = {DW{check}};
          g_n = {DW{check}};
          b_n = {DW{check}};
        end
      endcase
    end
`endif

    if (hblank_n || vblank_n) begin
      r_n = '0;
      g_n = '0;
      b_n = '0;
    end
  end

  // Divider, raster counters and registered video outputs.
  always_ff @(posedge CLK_VIDEO) begin
    if (reset) begin
      div    <= '0;
      ce_pix <= 1'b0;
      hcnt   <= H_LAST;
      vcnt   <= V_LAST;
      frame  <= 8'd0;
      HSync  <= 1'b0;
      VSync  <= 1'b0;
      HBlank <= 1'b1;
      VBlank <= 1'b1;
      R      <= '0;
      G      <= '0;
      B      <= '0;
    end else begin
      ce_pix <= stb;
      div    <= stb ? '0 : div + DIVW'(1);
      if (stb) begin
        hcnt   <= h_n;
        vcnt   <= v_n;
        frame  <= frame_n;
        HSync  <= hsync_n;
        VSync  <= vsync_n;
        HBlank <= hblank_n;
        VBlank <= vblank_n;
        R      <= r_n;
        G      <= g_n;
        B      <= b_n;
      end
    end
  end

`ifdef VIDEO_TIMING_GEN_PATTERN_EN
  // Pattern state: latched selection and colour-bar sub-counter.
  always_ff @(posedge CLK_VIDEO) begin
    if (reset) begin
      pat_q   <= 3'd0;
      bar_px  <= '0;
      bar_idx <= 3'd0;
    end else if (stb) begin
      pat_q   <= pat_n;
      bar_px  <= bar_px_n;
      bar_idx <= bar_idx_n;
    end
  end
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Self-checking bench for video_timing_gen: a frame-order arithmetic model predicts every
// output on every cycle, and directed literal checks pin timing boundaries and colours.
module tb_video_timing_gen;

  localparam int HA = 320, HF = 16, HS = 32, HB = 32;
  localparam int VA = 4, VF = 1, VS = 2, VB = 1;
  localparam int CD = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FP = HT * VT;

  logic       CLK_VIDEO = 1'b0;
  logic       reset;
  logic [2:0] pat_sel;
  logic [7:0] ext_R, ext_G, ext_B;
  logic       ce_pix, HSync, VSync, HBlank, VBlank;
  logic [7:0] R, G, B;
  logic [9:0] hcnt, vcnt;
  logic [7:0] frame;

  int n_cmp = 0;
  int n_bad = 0;

  video_timing_gen #(
    .HACTIVE(HA), .HFP(HF), .HSW(HS), .HBP(HB),
    .VACTIVE(VA), .VFP(VF), .VSW(VS), .VBP(VB),
    .CE_DIV(CD), .HALF_DEPTH(0)
  ) dut (
    .CLK_VIDEO(CLK_VIDEO), .reset(reset), .pat_sel(pat_sel),
    .ext_R(ext_R), .ext_G(ext_G), .ext_B(ext_B),
    .ce_pix(ce_pix), .HSync(HSync), .VSync(VSync), .HBlank(HBlank), .VBlank(VBlank),
    .R(R), .G(G), .B(B), .hcnt(hcnt), .vcnt(vcnt), .frame(frame)
  );

  always #5 CLK_VIDEO = ~CLK_VIDEO;

  // External source content for a given raster pixel.
  function automatic logic [23:0] ext_pix(input int h, input int v, input int f);
    logic [7:0] hr, gr, br;
    hr = 8'(h);
    gr = 8'(h + 17 * v) ^ 8'h3C;
    br = ~8'(h) ^ 8'(f);
    return {hr, gr, br};
  endfunction

`ifdef VIDEO_TIMING_GEN_PATTERN_EN
  function automatic logic [23:0] pat_pix(input logic [2:0] sel, input int h, input int v, input int f);
    int  i;
    bit  w;
    logic [23:0] c;
    case (sel[1:0])
      2'd0: begin
        i = h / (HA / 8);
        c = {(((i >> 1) & 1) != 0) ? 8'h00 : 8'hFF,
             (((i >> 2) & 1) != 0) ? 8'h00 : 8'hFF,
             ((i & 1) != 0)        ? 8'h00 : 8'hFF};
      end
      2'd1: begin
        w = (h % 16 == 0) || (v % 16 == 0) || (h == HA - 1) || (v == VA - 1);
        c = w ? 24'hFFFFFF : 24'h0;
      end
      2'd2: c = {8'(h), 8'(v), 8'(f)};
      default: begin
        w = (((h / 16) ^ (v / 16)) & 1) != 0;
        c = w ? 24'hFFFFFF : 24'h0;
      end
    endcase
    return c;
  endfunction
`endif

  // Model: edges since reset release determine the pixel index in frame order.
  int          n_edge = 0;
  bit          model_valid = 1'b0;
  logic [2:0]  pat_m = 3'd0;
  bit          e_ce, e_hs, e_vs, e_hb, e_vb;
  int          e_h, e_v, e_f;
  logic [23:0] e_rgb;

  always @(posedge CLK_VIDEO) begin
    int p, L;
    if (reset) begin
      n_edge      = 0;
      model_valid = 1'b1;
      pat_m       = 3'd0;
    end else begin
      n_edge = n_edge + 1;
    end
    p    = n_edge / CD;
    e_ce = (n_edge > 0) && (n_edge % CD == 0);
    if (p == 0) begin
      e_h = HT - 1; e_v = VT - 1; e_f = 0;
      e_hs = 1'b0; e_vs = 1'b0; e_hb = 1'b1; e_vb = 1'b1; e_rgb = 24'h0;
    end else begin
      L   = p - 1;
      e_h = L % HT;
      e_v = (L / HT) % VT;
      e_f = (L / FP + 1) % 256;
      if (e_ce && e_h == 0 && e_v == 0) pat_m = pat_sel;
      e_hb = (e_h >= HA);
      e_vb = (e_v >= VA);
      e_hs = (e_h >= HA + HF) && (e_h < HA + HF + HS);
      e_vs = (e_v >= VA + VF) && (e_v < VA + VF + VS);
      if (e_hb || e_vb) e_rgb = 24'h0;
`ifdef VIDEO_TIMING_GEN_PATTERN_EN
      else if (pat_m[2]) e_rgb = pat_pix(pat_m, e_h, e_v, e_f);
`endif
      else e_rgb = ext_pix(e_h, e_v, e_f);
    end
  end

  // External source presents the pixel that the next stb will emit.
  always @(posedge CLK_VIDEO) begin
    int nx;
    #1;
    nx = n_edge / CD;
    {ext_R, ext_G, ext_B} = ext_pix(nx % HT, (nx / HT) % VT, (nx / FP + 1) % 256);
  end

  task automatic summary_and_finish();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  endtask

  // Every-cycle comparison against the model.
  always @(negedge CLK_VIDEO) begin
    logic [56:0] act, exp;
    if (model_valid) begin
      act = {ce_pix, HSync, VSync, HBlank, VBlank, R, G, B, hcnt, vcnt, frame};
      exp = {e_ce, e_hs, e_vs, e_hb, e_vb, e_rgb, 10'(e_h), 10'(e_v), 8'(e_f)};
      n_cmp = n_cmp + 1;
      if (act !== exp) begin
        n_bad = n_bad + 1;
        $display("FAIL model t=%0t got %h want %h (ce,hs,vs,hb,vb,rgb,h,v,f)", $time, act, exp);
        if (n_bad >= 50) summary_and_finish();
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Advance to the negedge where the model shows pixel (h,v) of frame f freshly emitted.
  task automatic wait_pix(input int h, input int v, input int f);
    int k;
    k = 0;
    do begin
      @(negedge CLK_VIDEO);
      k = k + 1;
    end while (!(e_ce && e_h == h && e_v == v && e_f == f) && k < 40000);
    if (k >= 40000) begin
      n_cmp = n_cmp + 1;
      n_bad = n_bad + 1;
      $display("FAIL wait_pix: timeout waiting for (%0d,%0d) frame %0d", h, v, f);
    end
  endtask

  task automatic chk_rgb(input string nm, input logic [23:0 ] exp);
    chk(nm, 32'({R, G, B}), 32'(exp));
  endtask

  initial begin
    reset   = 1'b1;
    pat_sel = 3'b000;
    repeat (3) @(posedge CLK_VIDEO);
    @(negedge CLK_VIDEO);
    chk("rst_hcnt", 32'(hcnt), 32'd399);
    chk("rst_vcnt", 32'(vcnt), 32'd7);
    chk("rst_flags", 32'({ce_pix, HSync, VSync, HBlank, VBlank}), 32'b00011);
    chk("rst_frame", 32'(frame), 32'd0);
    chk_rgb("rst_rgb", 24'h0);
    reset = 1'b0;

    wait_pix(0, 0, 1);
    chk("first_pos", 32'({hcnt, vcnt}), 32'd0);
    chk("first_blank", 32'({HBlank, VBlank}), 32'd0);
    chk("first_frame", 32'(frame), 32'd1);
    chk("first_ce", 32'(ce_pix), 32'd1);
    @(negedge CLK_VIDEO);
    chk("ce_low_after", 32'(ce_pix), 32'd0);

    wait_pix(319, 0, 1);
    chk("hb_319", 32'(HBlank), 32'd0);
    chk_rgb("pass_319", {8'h3F, 8'(319) ^ 8'h3C, ~8'(319) ^ 8'd1});
    wait_pix(320, 0, 1);
    chk("hb_320", 32'(HBlank), 32'd1);
    chk_rgb("blank_320", 24'h0);
    wait_pix(335, 0, 1); chk("hs_335", 32'(HSync), 32'd0);
    wait_pix(336, 0, 1); chk("hs_336", 32'(HSync), 32'd1);
    wait_pix(367, 0, 1); chk("hs_367", 32'(HSync), 32'd1);
    wait_pix(368, 0, 1); chk("hs_368", 32'(HSync), 32'd0);
    wait_pix(200, 1, 1); chk("pass_r_200", 32'(R), 32'hC8);
    wait_pix(0, 3, 1);   chk("vb_3", 32'(VBlank), 32'd0);
    wait_pix(0, 4, 1);   chk("vb_4", 32'(VBlank), 32'd1);
    wait_pix(399, 4, 1); chk("vs_end4", 32'(VSync), 32'd0);
    wait_pix(0, 5, 1);   chk("vs_5", 32'(VSync), 32'd1);
    wait_pix(399, 6, 1); chk("vs_6", 32'(VSync), 32'd1);
    wait_pix(0, 7, 1);   chk("vs_7", 32'(VSync), 32'd0);

`ifndef VIDEO_TIMING_GEN_PATTERN_EN
    pat_sel = 3'b110;
`endif
    wait_pix(0, 0, 4);
    chk("frame_4", 32'(frame), 32'd4);
    chk("frame_4_pos", 32'({hcnt, vcnt}), 32'd0);

    // Reset for one clock in the middle of a line.
    wait_pix(150, 2, 4);
    reset = 1'b1;
    @(negedge CLK_VIDEO);
    chk("mid_rst_pos", 32'({hcnt, vcnt}), 32'({10'd399, 10'd7}));
    chk("mid_rst_flags", 32'({ce_pix, HSync, VSync, HBlank, VBlank}), 32'b00011);
    chk("mid_rst_frame", 32'(frame), 32'd0);
    reset = 1'b0;
    wait_pix(0, 0, 1);
    chk("post_rst_pos", 32'({hcnt, vcnt}), 32'd0);
    chk("post_rst_frame", 32'(frame), 32'd1);

`ifdef VIDEO_TIMING_GEN_PATTERN_EN
    pat_sel = 3'b100;
    wait_pix(0, 0, 2);   chk_rgb("bar_0", 24'hFFFFFF);
    wait_pix(39, 0, 2);  chk_rgb("bar_39", 24'hFFFFFF);
    wait_pix(40, 0, 2);  chk_rgb("bar_40", 24'hFFFF00);
    wait_pix(280, 0, 2); chk_rgb("bar_280", 24'h000000);
    wait_pix(320, 0, 2); chk_rgb("bar_320", 24'h000000);
    wait_pix(10, 2, 2);
    pat_sel = 3'b101;
    wait_pix(40, 2, 2);  chk_rgb("bar_hold", 24'hFFFF00);
    wait_pix(0, 0, 3);   chk_rgb("grid_0", 24'hFFFFFF);
    wait_pix(40, 1, 3);  chk_rgb("grid_40_1", 24'h000000);
    wait_pix(319, 1, 3); chk_rgb("grid_319", 24'hFFFFFF);
    wait_pix(16, 2, 3);  chk_rgb("grid_16", 24'hFFFFFF);
    wait_pix(40, 3, 3);  chk_rgb("grid_lastrow", 24'hFFFFFF);
    pat_sel = 3'b110;
    wait_pix(5, 2, 4);   chk_rgb("grad", 24'h050204);
    pat_sel = 3'b111;
    wait_pix(16, 0, 5);  chk_rgb("check_16", 24'hFFFFFF);
    wait_pix(32, 0, 5);  chk_rgb("check_32", 24'h000000);
`endif

    repeat (5) @(negedge CLK_VIDEO);
    summary_and_finish();
  end

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Video source for the sys video path. Generates ce_pix, HSync/VSync, HBlank/VBlank and RGB in the format that video_mixer-style consumers accept on their input side.
- Serves as the bring-up and test source for scaler, scandoubler and HDMI paths. It also provides a raster-timing master for cores that render from pixel coordinates.
- All outputs are registered and run in the CLK_VIDEO domain.

Parameters:
- HACTIVE, 320: visible pixels per line. Must be a multiple of 8.
- HFP, 16: horizontal front porch, in pixels.
- HSW, 32: HSync width, in pixels.
- HBP, 32: horizontal back porch, in pixels.
- VACTIVE, 240: visible lines.
- VFP, 3: vertical front porch, in lines.
- VSW, 4: VSync width, in lines.
- VBP, 15: vertical back porch, in lines.
- CE_DIV, 4: CLK_VIDEO cycles per pixel. Must be 2 or more.
- HALF_DEPTH, 0: 1 selects 4-bit colour components, 0 selects 8-bit.

Ports:
- CLK_VIDEO  in  1  video clock
- reset  in  1  synchronous, active-high
- pat_sel  in  3  [2]=1 selects a pattern, [1:0] is the pattern number; [2]=0 selects passthrough
- ext_R, ext_G, ext_B  in  DW each  external pixel for passthrough mode (DW = HALF_DEPTH ? 4 : 8)
- ce_pix  out  1  pixel clock enable, high for one cycle
- HSync, VSync  out  1  positive sync pulses
- HBlank, VBlank  out  1  positive blanking
- R, G, B  out  DW each  pixel colour
- hcnt  out  10  horizontal position of the pixel currently on the outputs
- vcnt  out  10  vertical position of the pixel currently on the outputs
- frame  out  8  frame counter

Behaviour:
- Clock and reset: single clock CLK_VIDEO. reset is synchronous and active-high.
- Totals: HTOTAL = HACTIVE+HFP+HSW+HBP; VTOTAL = VACTIVE+VFP+VSW+VBP.
- Pixel divider:
  - div counts 0..CE_DIV-1 and wraps.
  - Internal strobe stb = (div == CE_DIV-1).
  - ce_pix is registered stb, so it is high on exactly one cycle in every CE_DIV.
- Counter advance (on each edge where stb=1):
  - h increments; at HTOTAL-1 it wraps to 0 and v increments.
  - v wraps from VTOTAL-1 to 0.
  - All video outputs update on that same edge from the new h and v, so they change in the cycle ce_pix goes high.
  - hcnt/vcnt equal the new h/v.
- Timing decode, evaluated on the new h/v:
  - HBlank = h >= HACTIVE.
  - HSync = HACTIVE+HFP <= h < HACTIVE+HFP+HSW.
  - VBlank = v >= VACTIVE.
  - VSync = VACTIVE+VFP <= v < VACTIVE+VFP+VSW. VSync changes only together with the h 0 transition.
- Frame start is the transition to h=0, v=0. On it:
  - frame increments modulo 256.
  - pat_sel is latched into pat_q. A pat_sel change mid-frame takes effect at the next frame only.
- RGB:
  - Forced to 0 whenever HBlank or VBlank is set on the new position.
  - Passthrough (pat_q[2]=0): ext_* are sampled on the stb edge and become the output pixel for the new h/v. The external source therefore presents pixel (hcnt+1) while hcnt holds the previous pixel, i.e. one-pixel lookahead.
- Reset:
  - div=0, h=HTOTAL-1, v=VTOTAL-1, frame=0, pat_q=0.
  - Outputs: ce_pix=0, HSync=0, VSync=0, HBlank=1, VBlank=1, RGB=0, hcnt=HTOTAL-1, vcnt=VTOTAL-1.
  - The first stb after reset release produces pixel (0,0). frame becomes 1 on that edge.
  - Reset asserted mid-line returns to this state on the next edge; no partial line is completed.
- Pattern colours: "full" = all ones at DW bits.

Optional Feature:
- Macro: VIDEO_TIMING_GEN_PATTERN_EN.
- Defined: pattern logic is compiled in and used when pat_q[2]=1. Patterns by pat_q[1:0]:
  - 0, colour bars: 8 bars, each HACTIVE/8 wide, bar index i counted from 0 at left. R=full when ~i[1], G=full when ~i[2], B=full when ~i[0]. Order is white, yellow, cyan, green, magenta, red, blue, black. The bar index comes from a sub-counter, not a divider.
  - 1, grid: white when h[3:0]==0, v[3:0]==0, h==HACTIVE-1 or v==VACTIVE-1; black otherwise.
  - 2, gradient: R=h[DW-1:0], G=v[DW-1:0], B=frame[DW-1:0].
  - 3, checkerboard: white when h[4]^v[4], else black.
- Undefined: the module is always in passthrough, pat_sel[2:0] is ignored, and no pattern logic is synthesised.
- Blanking-forces-zero applies in both builds.

Test Plan:
- Default parameters, reset released: ce_pix period is 4 clocks. HTOTAL=400, VTOTAL=262.
  - HSync is high for 32 pixels starting at hcnt=336.
  - VSync is high for lines 243..246.
  - HBlank rises at hcnt=320; VBlank rises at vcnt=240.
- First stb after reset: outputs hcnt=0, vcnt=0, HBlank=0, VBlank=0, frame=1. Three full frames later: frame=4.
- Colour bars, HALF_DEPTH=0, macro defined:
  - hcnt=0..39 gives FF/FF/FF.
  - hcnt=40 gives FF/FF/00.
  - hcnt=280..319 gives 00/00/00.
  - hcnt=320 gives 0/0/0 (blanked).
- pat_sel changes from 3'b100 to 3'b101 at vcnt=100: bars continue to the end of the frame. The grid appears from (0,0) of the next frame.
- Passthrough: ext_R driven equal to (hcnt+1) low bits. R equals hcnt[7:0] for all active pixels. R=0 in blanking.
- Reset asserted at hcnt=150, vcnt=50 for one clock: next cycle shows the reset state. The first pixel after release is (0,0).
